// File: rtl/mac4591s33_pkg.sv
// Shared sntrup761 mod-4591 constants and operand/accumulator types,
// common to the MAC and the downstream 33-bit reducer.
package ntru4591_pkg;

   localparam int NTRU_Q  = 4591;
   localparam int NTRU_QH = 2295;

   localparam int RES_W  = 13;
   localparam int PROD_W = 26;
   localparam int ACC_W  = 33;

   typedef logic signed [RES_W-1:0]  res_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // True when a centered residue lies inside -NTRU_QH..NTRU_QH.
   function automatic logic in_range(input res_t x);
      res_t lim;
      lim = res_t'(NTRU_QH);
      return (x >= -lim) && (x <= lim);
   endfunction

endpackage

// File: rtl/mac4591s33_if.sv
// Operand-pair input stream and dot-product result stream of the MAC.
interface mac4591s33_if;
   import ntru4591_pkg::*;

   logic  in_valid;
   logic  in_ready;
   res_t  in_a;
   res_t  in_b;
   logic  out_valid;
   logic  out_ready;
   acc_t  out_sum;
   logic  out_err;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_err
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_err
   );

endinterface

// File: rtl/mac4591s33_mul13s.sv
// Registered 13x13 signed multiplier with hold enable; also flags
// operands outside the centered range.
module mul13s
   import ntru4591_pkg::*;
(
   input  logic  clk,
   input  logic  Reset_n,
   input  logic  i_en,
   input  res_t  i_a,
   input  res_t  i_b,
   output prod_t o_prod,
   output logic  o_err
);

   prod_t r_prod;
   logic  r_err;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_prod <= '0;
         r_err  <= 1'b0;
      end else if (i_en) begin
         r_prod <= i_a * i_b;
         r_err  <= ~(in_range(i_a) & in_range(i_b));
      end
   end

   assign o_prod = r_prod;
   assign o_err  = r_err;

endmodule

// File: rtl/mac4591s33.sv
// Streaming signed multiply-accumulate: LEN products of centered residues
// summed exactly into a 33-bit signed result with an out-of-range flag.
module mac4591s33
   import ntru4591_pkg::*;
#(
   parameter int LEN = 761
)
(
   input  logic         clk,
   input  logic         Reset_n,
   input  logic         clear,
   mac4591s33_if.slave  bus
);

   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_LAST = cnt_t'(LEN - 1);

   cnt_t  r_cnt;
   logic  r_p_v;
   logic  r_p_first;
   logic  r_p_last;
   acc_t  r_acc;
   logic  r_err_acc;
   logic  r_out_valid;
   acc_t  r_out_sum;
   logic  r_out_err;

   prod_t w_prod;
   logic  w_p_err;
   logic  w_stall;
   logic  w_accept;
   logic  w_fire;
   logic  w_first;
   logic  w_last;
   logic  w_mul_en;
   acc_t  w_prod_ext;
   acc_t  w_sum;
   logic  w_err;

   // A finished product cannot leave stage 2 while the previous result is
   // still unclaimed; everything upstream then freezes.
   always_comb begin
      w_stall    = r_p_v & r_p_last & r_out_valid & ~bus.out_ready;
      w_accept   = bus.in_valid & ~w_stall & ~clear;
      w_fire     = r_p_v & ~w_stall & ~clear;
      w_mul_en   = ~w_stall;
      w_first    = (r_cnt == '0);
      w_last     = (r_cnt == CNT_LAST);
      w_prod_ext = acc_t'({{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod});
      w_sum      = r_p_first ? w_prod_ext : r_acc + w_prod_ext;
      w_err      = r_p_first ? w_p_err : (r_err_acc | w_p_err);
   end

   mul13s u_mul (
      .clk     (clk),
      .Reset_n (Reset_n),
      .i_en    (w_mul_en),
      .i_a     (bus.in_a),
      .i_b     (bus.in_b),
      .o_prod  (w_prod),
      .o_err   (w_p_err)
   );

   // Stage 1 control: term counter and first/last tags.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt     <= '0;
         r_p_v     <= 1'b0;
         r_p_first <= 1'b0;
         r_p_last  <= 1'b0;
      end else if (clear) begin
         r_cnt <= '0;
         r_p_v <= 1'b0;
      end else if (!w_stall) begin
         r_p_v <= w_accept;
         if (w_accept) begin
            r_p_first <= w_first;
            r_p_last  <= w_last;
            r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
         end
      end
   end

   // Stage 2: accumulator and result register.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_acc       <= '0;
         r_err_acc   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_err   <= 1'b0;
      end else begin
         if (w_fire) begin
            r_acc     <= w_sum;
            r_err_acc <= w_err;
         end
         if (w_fire && r_p_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_err   <= w_err;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = ~w_stall;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_err   = r_out_err;

endmodule
